// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver.
// Active-high glyphs {g,f,e,d,c,b,a}, seg bus bit positions, blank value.
package seg7_scan_driver_pkg;

    localparam int NIB_W = 4;
    localparam int SEG_W = 8;
    localparam int GLYPH_W = 7;

    // seg bus layout {dp,g,f,e,d,c,b,a}
    localparam int SEG_A_BIT  = 0;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    localparam logic [GLYPH_W-1:0] SEG_0 = 7'h3F;
    localparam logic [GLYPH_W-1:0] SEG_1 = 7'h06;
    localparam logic [GLYPH_W-1:0] SEG_2 = 7'h5B;
    localparam logic [GLYPH_W-1:0] SEG_3 = 7'h4F;
    localparam logic [GLYPH_W-1:0] SEG_4 = 7'h66;
    localparam logic [GLYPH_W-1:0] SEG_5 = 7'h6D;
    localparam logic [GLYPH_W-1:0] SEG_6 = 7'h7D;
    localparam logic [GLYPH_W-1:0] SEG_7 = 7'h07;
    localparam logic [GLYPH_W-1:0] SEG_8 = 7'h7F;
    localparam logic [GLYPH_W-1:0] SEG_9 = 7'h6F;
    localparam logic [GLYPH_W-1:0] SEG_A = 7'h77;
    localparam logic [GLYPH_W-1:0] SEG_B = 7'h7C;
    localparam logic [GLYPH_W-1:0] SEG_C = 7'h39;
    localparam logic [GLYPH_W-1:0] SEG_D = 7'h5E;
    localparam logic [GLYPH_W-1:0] SEG_E = 7'h79;
    localparam logic [GLYPH_W-1:0] SEG_F = 7'h71;

    // All segments and dp dark, active-high sense
    localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;

    typedef struct packed {
        logic                dp;
        logic [GLYPH_W-1:0]  glyph;
    } seg_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-high 7-segment glyph, purely combinational.
// Ports: nib (4b hex value) -> glyph ({g,f,e,d,c,b,a}).
module seg7_hex_decoder
    import seg7_scan_driver_pkg::*;
(
    input  logic [NIB_W-1:0]   nib,
    output logic [GLYPH_W-1:0] glyph
);

    always_comb begin
        glyph = SEG_0;
        unique case (nib)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
            default: glyph = SEG_0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with per-frame input snapshot
// and anti-ghosting guard gap.
// Ports: clk, rst (sync, active-high); data (4b per digit), dp_in, digit_en
// in; an_out (digit select), seg_out ({dp,g..a}), frame_tick (frame start).
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int CLK_DIV    = 100000,
    parameter int GUARD      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NIB_W*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]       dp_in,
    input  logic [N_DIGITS-1:0]       digit_en,
    output logic [N_DIGITS-1:0]       an_out,
    output logic [SEG_W-1:0]          seg_out,
    output logic                      frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(CLK_DIV);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_DIGITS - 1);

    // Output polarity mask: XOR with all-ones flips to active-low
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_POL  = {N_DIGITS{POL}};
    localparam logic [SEG_W-1:0]    SEG_POL = {SEG_W{POL}};

    // Scan position
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             slot_end;
    logic             frame_end;
    logic             in_guard;

    // Snapshot of the inputs taken at each frame boundary
    logic [NIB_W-1:0]    sh_nib [N_DIGITS];
    logic [N_DIGITS-1:0] sh_dp;
    logic [N_DIGITS-1:0] sh_en;

    // Current-digit view of the snapshot
    logic [NIB_W-1:0]    cur_nib;
    logic                cur_dp;
    logic                cur_en;
    logic [GLYPH_W-1:0]  cur_glyph;

    // Active-high next values for the output registers
    logic [N_DIGITS-1:0] an_hi;
    seg_t                seg_hi;

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == IDX_MAX);

    generate
        if (GUARD == 0) begin : g_noguard
            assign in_guard = 1'b0;
        end else begin : g_guard
            localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
            assign in_guard = (cnt < GUARD_C);
        end
    endgenerate

    // Prescaler and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow registers: inputs are only observed on the frame boundary,
    // so a value change mid-frame never tears the displayed number.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                sh_nib[i] <= '0;
            end
            sh_dp <= '0;
            sh_en <= '0;
        end else if (frame_end) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                sh_nib[i] <= data[NIB_W*i +: NIB_W];
            end
            sh_dp <= dp_in;
            sh_en <= digit_en;
        end
    end

    assign cur_nib = sh_nib[idx];
    assign cur_dp  = sh_dp[idx];
    assign cur_en  = sh_en[idx];

    seg7_hex_decoder u_dec (
        .nib   (cur_nib),
        .glyph (cur_glyph)
    );

    // Anode is held dark at the start of each slot so the previous
    // digit's segments never flash on the new digit.
    always_comb begin
        an_hi  = '0;
        seg_hi = SEG_OFF;
        if (cur_en) begin
            seg_hi.glyph = cur_glyph;
            seg_hi.dp    = cur_dp;
            if (!in_guard) begin
                an_hi[idx] = 1'b1;
            end
        end
    end

    // Registered, polarity-corrected outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            an_out     <= AN_POL;
            seg_out    <= SEG_OFF ^ SEG_POL;
            frame_tick <= 1'b0;
        end else begin
            an_out     <= an_hi ^ AN_POL;
            seg_out    <= seg_hi ^ SEG_POL;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, div 4, guard 1, active-low).
// Expected outputs come from a cycle model pushed each clock, popped after it.
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int GRD = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  an_out;
    logic [7:0]  seg_out;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS   (N),
        .CLK_DIV    (DIV),
        .GUARD      (GRD),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .an_out     (an_out),
        .seg_out    (seg_out),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       ft;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int tn = 0;

    logic [6:0] lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Reference model state
    int          m_idx = 0;
    int          m_cnt = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_en = '0;

    // Last observed outputs
    logic [3:0] o_an;
    logic [7:0] o_seg;
    logic       o_ft;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s tick %0d got %h expected %h", tag, tn, got, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic [3:0] an_h;
        logic [7:0] seg_h;
        logic       bnd;
        bnd = (m_cnt == DIV - 1) && (m_idx == N - 1);
        if (rst) begin
            e = '{an: 4'hF, seg: 8'hFF, ft: 1'b0};
        end else begin
            an_h  = 4'h0;
            seg_h = 8'h00;
            if (m_en[m_idx]) begin
                seg_h = {m_dp[m_idx], lut[m_data[m_idx*4 +: 4]]};
                if (m_cnt >= GRD) an_h = 4'(1 << m_idx);
            end
            e = '{an: ~an_h, seg: ~seg_h, ft: bnd};
        end
        sb.push_back(e);
        if (rst) begin
            m_idx = 0; m_cnt = 0;
            m_data = '0; m_dp = '0; m_en = '0;
        end else begin
            if (bnd) begin
                m_data = data; m_dp = dp_in; m_en = digit_en;
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
        tn++;
        o_an  = an_out;
        o_seg = seg_out;
        o_ft  = frame_tick;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("sb_an", o_an, e.an);
            check("sb_seg", o_seg, e.seg);
            check("sb_ft", o_ft, e.ft);
        end
    endtask

    task automatic run_to(int t);
        while (tn < t) tick();
    endtask

    initial begin
        rst = 1'b1;
        data = '0;
        dp_in = '0;
        digit_en = '0;

        repeat (3) begin
            tick();
            check("rst_an", o_an, 4'hF);
            check("rst_seg", o_seg, 8'hFF);
            check("rst_ft", o_ft, 1'b0);
        end

        rst = 1'b0;
        data = 16'h1234;
        digit_en = 4'hF;
        tn = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("blank_an", o_an, 4'hF);
            check("first_ft", o_ft, i == 16);
        end

        // Frame 1: snapshot 1234 all enabled; new dp/en wait for frame 2
        dp_in = 4'b0010;
        digit_en = 4'b1011;
        tick();
        check("guard_an", o_an, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("d0_an", o_an, 4'b1110);
            check("d0_seg", o_seg, 8'h99);
        end
        run_to(22);
        check("d1_nodp_seg", o_seg, 8'hB0);
        run_to(32);
        check("f1_ft", o_ft, 1'b1);

        // Frame 2: dp on digit1, digit2 blanked
        run_to(38);
        check("d1_an", o_an, 4'b1101);
        check("d1_dp_seg", o_seg, 8'h30);
        data = 16'hFFFF;
        run_to(42);
        check("d2_off_an", o_an, 4'hF);
        check("d2_off_seg", o_seg, 8'hFF);
        run_to(46);
        check("d3_an", o_an, 4'b0111);
        check("d3_hold_seg", o_seg, 8'hF9);

        // Frame 3: FFFF now visible
        run_to(50);
        check("f3_an", o_an, 4'b1110);
        check("f3_seg", o_seg, 8'h8E);

        // Reset during the digit2 slot
        run_to(57);
        rst = 1'b1;
        tick();
        check("mid_rst_an", o_an, 4'hF);
        check("mid_rst_seg", o_seg, 8'hFF);
        check("mid_rst_ft", o_ft, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("rblank_an", o_an, 4'hF);
            check("rblank_seg", o_seg, 8'hFF);
            check("rfirst_ft", o_ft, i == 16);
        end
        tick();
        tick();
        check("post_rst_an", o_an, 4'b1110);
        check("post_rst_seg", o_seg, 8'h8E);
        repeat (14) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
